tiny32_intc: RTL

TINY32_INTC -- requirements
Module: tiny32_intc

---
 rtl/tiny32_intc.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tiny32_intc.sv
// Eight-source interrupt controller for the tiny32 core: level/edge, polarity, ack-based clearing.
// Optional INTC_SYNC_EN adds a second irq synchronizer flop (one extra cycle of latency).
module tiny32_intc #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [7:0]  irq,
  output logic [7:0]  interrupt,
  input  logic [7:0]  interrupt_ack,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        nrd,
  input  logic [3:0]  nwr,
  output logic        ready
);

  logic [7:0]  enable_r, pending_r, mode_r, polarity_r;
  logic [7:0]  interrupt_r, prev_s_r, ack_prev_r;
  logic [31:0] data_out_r;
  logic        ready_r;
  logic [7:0]  irq_sampled_s, active_s, rise_s, w1c_s, ack_clr_s, pending_next_s;
  logic [7:0]  rd_mux_s;
  logic        sel_s, first_s, wr_s, rd_s, ack_rise_s;
  logic        unused_s;

  // Returns a one-hot mask of the highest set bit, zero when nothing is set.
  function automatic logic [7:0] highest_bit(input logic [7:0] v);
    logic [7:0] res;
    res = 8'h00;
    for (int i = 0; i < 8; i++) begin
      res = v[i] ? (8'h01 << i) : res;
    end
    return res;
  endfunction

  assign unused_s = ^{address[1:0], data_in[31:8]};

  assign sel_s   = (address[31:4] == BASE_ADDRESS[31:4]) & (~nrd | (nwr != 4'b1111));
  // ready doubles as the delayed sel, so first_s marks the single cycle where the access acts
  assign first_s = sel_s & ~ready_r;
  assign wr_s    = first_s & ~nwr[0];
  assign rd_s    = first_s & ~nrd;

`ifdef INTC_SYNC_EN
  logic [7:0] sync1_r, sync2_r;
  // Two-flop synchronizer for asynchronous peripheral requests.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_r <= 8'h00;
      sync2_r <= 8'h00;
    end else begin
      sync1_r <= irq;
      sync2_r <= sync1_r;
    end
  end
  assign irq_sampled_s = sync2_r;
`else
  logic [7:0] sync1_r;
  // Single sampling stage for requests already synchronous to clk.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_r <= 8'h00;
    end else begin
      sync1_r <= irq;
    end
  end
  assign irq_sampled_s = sync1_r;
`endif

  // Next PENDING: edge sources set on rise (set beats clear), level sources follow the active level.
  always_comb begin
    active_s   = irq_sampled_s ^ polarity_r;
    rise_s     = active_s & ~prev_s_r;
    ack_rise_s = (ack_prev_r == 8'h00) && (interrupt_ack != 8'h00);
    w1c_s      = 8'h00;
    ack_clr_s  = 8'h00;
    if (wr_s && (address[3:2] == 2'd1)) begin
      w1c_s = data_in[7:0];
    end else begin
      w1c_s = 8'h00;
    end
    if (ack_rise_s) begin
      ack_clr_s = highest_bit(interrupt_ack & mode_r);
    end else begin
      ack_clr_s = 8'h00;
    end
    pending_next_s = (mode_r & ((pending_r & ~(w1c_s | ack_clr_s)) | rise_s))
                   | (~mode_r & active_s);
  end

  // Register read multiplexer.
  always_comb begin
    rd_mux_s = 8'h00;
    case (address[3:2])
      2'd0:    rd_mux_s = enable_r;
      2'd1:    rd_mux_s = pending_r;
      2'd2:    rd_mux_s = mode_r;
      2'd3:    rd_mux_s = polarity_r;
      default: rd_mux_s = 8'h00;
    endcase
  end

  // Bus handshake, read capture and configuration register writes.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ready_r    <= 1'b0;
      data_out_r <= 32'h0;
      enable_r   <= 8'h00;
      mode_r     <= 8'h00;
      polarity_r <= 8'h00;
    end else begin
      ready_r <= sel_s;
      if (rd_s) begin
        data_out_r <= {24'h0, rd_mux_s};
      end
      if (wr_s) begin
        case (address[3:2])
          2'd0:    enable_r   <= data_in[7:0];
          2'd2:    mode_r     <= data_in[7:0];
          2'd3:    polarity_r <= data_in[7:0];
          default: enable_r   <= enable_r;
        endcase
      end
    end
  end

  // Interrupt state: pending, edge/ack history and the registered request vector.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pending_r   <= 8'h00;
      prev_s_r    <= 8'h00;
      ack_prev_r  <= 8'h00;
      interrupt_r <= 8'h00;
    end else begin
      pending_r   <= pending_next_s;
      prev_s_r    <= active_s;
      ack_prev_r  <= interrupt_ack;
      interrupt_r <= pending_r & enable_r;
    end
  end

  assign interrupt = interrupt_r;
  assign data_out  = data_out_r;
  assign ready     = ready_r;

endmodule
